// File: rtl/hidden_unit_mac_reader_if.sv
// Request/response and memory-read signal bundle for the hidden-unit MAC reader.
// The requester (master) drives start/base_addr/len and returns RAM/vector read data.
interface hidden_unit_mac_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ACC_WIDTH  = 21
);
  logic                         start;
  logic [ADDR_WIDTH-1:0]        base_addr;
  logic [ADDR_WIDTH:0]          len;
  logic [ADDR_WIDTH-1:0]        ram_addr;
  logic                         ram_we;
  logic signed [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0]        vec_addr;
  logic signed [DATA_WIDTH-1:0] vec_q;
  logic                         busy;
  logic                         done;
  logic signed [ACC_WIDTH-1:0]  result;

  modport master (
    output start, base_addr, len, ram_q, vec_q,
    input  ram_addr, ram_we, vec_addr, busy, done, result
  );

  modport slave (
    input  start, base_addr, len, ram_q, vec_q,
    output ram_addr, ram_we, vec_addr, busy, done, result
  );
endinterface

// File: rtl/hidden_unit_mac_reader.sv
// Walks len weights from base_addr in the weight RAM, pairs each with vector element i,
// and accumulates the signed dot product; result is presented with a 1-cycle done pulse.
module hidden_unit_mac_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ACC_WIDTH  = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  hidden_unit_mac_reader_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int PROD_W = 2 * DATA_WIDTH;

  function automatic logic signed [ACC_WIDTH-1:0] mac_term(
    input logic signed [DATA_WIDTH-1:0] w,
    input logic signed [DATA_WIDTH-1:0] x
  );
    logic signed [PROD_W-1:0] p;
    p = w * x;
    return {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  logic [1:0]                  state;
  logic [ADDR_WIDTH-1:0]       base_p0;
  logic [ADDR_WIDTH:0]         len_p0;
  logic [ADDR_WIDTH:0]         cnt;
  logic                        vld_p1;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] term_p1;
  logic signed [ACC_WIDTH-1:0] result;
  logic                        done;
  logic                        busy;

  // Stage p0: address issue (combinational off the walk counter)
  assign bus.ram_addr = (state == READ) ? base_p0 + cnt[ADDR_WIDTH-1:0] : '0;
  assign bus.vec_addr = (state == READ) ? cnt[ADDR_WIDTH-1:0] : '0;
  assign bus.ram_we   = 1'b0;

  // Stage p1: read data returns one cycle after its address
  assign term_p1 = mac_term(bus.ram_q, bus.vec_q);

  assign bus.result = result;
  assign bus.done   = done;
  assign bus.busy   = busy;

  // Request operands are held for the whole walk so mid-op input changes are harmless.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start && bus.len != '0) begin
      base_p0 <= bus.base_addr;
      len_p0  <= bus.len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
      acc    <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      done   <= 1'b0;
      vld_p1 <= (state == READ);
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy <= 1'b1;
            if (bus.len != '0) begin
              acc   <= '0;
              cnt   <= '0;
              state <= READ;
            end else begin
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        READ: begin
          if (vld_p1) acc <= acc + term_p1;
          cnt <= cnt + 1'b1;
          if (cnt == len_p0 - 1'b1) state <= DRAIN;
        end
        DRAIN: begin
          // The final product arrives here; fold it straight into the result.
          result <= acc + term_p1;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_unit_mac_reader.sv
// Randomized bench for hidden_unit_mac_reader with behavioural weight RAM / vector store
// and a plain-arithmetic dot-product reference.
module tb_hidden_unit_mac_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  logic signed [7:0] wmem [32];
  logic signed [7:0] vmem [32];

  hidden_unit_mac_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .ACC_WIDTH(21)) bus ();

  hidden_unit_mac_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .ACC_WIDTH(21)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Registered-read memories: data for an address appears one cycle later.
  always @(posedge clk) begin
    bus.ram_q <= wmem[bus.ram_addr];
    bus.vec_q <= vmem[bus.vec_addr];
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_dot(input int b, input int l);
    longint s = 0;
    for (int i = 0; i < l; i++)
      s += longint'(wmem[(b + i) % 32]) * longint'(vmem[i]);
    return s;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) begin
      wmem[i] = 8'($urandom);
      vmem[i] = 8'($urandom);
    end
  endtask

  task automatic run_op(input int b, input int l, input bit inject, input string tag,
                        output longint res);
    int k;
    bit seen;
    longint exp;
    exp  = model_dot(b, l);
    seen = 1'b0;
    res  = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = b[4:0];
    bus.len       = l[5:0];
    @(posedge clk);
    for (k = 0; k < 80; k++) begin
      @(negedge clk);
      bus.start     = inject && (k == 1);
      bus.base_addr = 5'($urandom);
      bus.len       = 6'($urandom_range(0, 32));
      if (k < l) begin
        chk({tag, "_raddr"}, longint'(bus.ram_addr), longint'((b + k) % 32));
        chk({tag, "_vaddr"}, longint'(bus.vec_addr), longint'(k));
      end
      if (l == 0 && k == 0) chk({tag, "_raddr0"}, longint'(bus.ram_addr), 0);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, seen ? longint'(k + 1) : -1, (l == 0) ? 1 : longint'(l + 2));
    if (seen) begin
      res = longint'($signed(bus.result));
      chk({tag, "_result"}, res, exp);
      chk({tag, "_busy_at_done"}, longint'(bus.busy), 1);
      chk({tag, "_we"}, longint'(bus.ram_we), 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, longint'(bus.done), 0);
      chk({tag, "_busy_after"}, longint'(bus.busy), 0);
    end
  endtask

  initial begin
    longint r;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    fill_rand();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", longint'(bus.busy), 0);
    chk("reset_done", longint'(bus.done), 0);
    chk("reset_result", longint'($signed(bus.result)), 0);
    chk("reset_raddr", longint'(bus.ram_addr), 0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      wmem[i] = 8'(i + 1);
      vmem[i] = 8'(i + 5);
    end
    run_op(0, 4, 1'b0, "basic", r);
    chk("basic_const", r, 70);

    for (int i = 0; i < 32; i++) begin
      wmem[i] = -8'sd128;
      vmem[i] = -8'sd128;
    end
    run_op(0, 32, 1'b0, "maxpos", r);
    chk("maxpos_const", r, 524288);
    for (int i = 0; i < 32; i++) vmem[i] = 8'sd127;
    run_op(0, 32, 1'b0, "maxneg", r);
    chk("maxneg_const", r, -520192);

    fill_rand();
    run_op(30, 4, 1'b0, "wrap", r);
    run_op(7, 0, 1'b0, "len0", r);
    chk("len0_const", r, 0);
    run_op(5, 10, 1'b1, "ignore", r);

    // Abort a walk with reset, then confirm a clean restart.
    for (int i = 0; i < 32; i++) wmem[i] = 8'sd3;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = 5'd2;
    bus.len       = 6'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_result", longint'($signed(bus.result)), 0);
    chk("rst_raddr", longint'(bus.ram_addr), 0);
    rst = 1'b0;
    fill_rand();
    run_op(12, 9, 1'b0, "after_rst", r);

    for (int n = 0; n < 20; n++) begin
      fill_rand();
      run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), 1'($urandom),
             "rand", r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
